// File: rtl/tinyalu_pkg.sv
// Shared TinyALU types: op encoding, queued command
// bundle and the op-width constant.
package tinyalu_pkg;

   localparam int OP_W   = 3;
   localparam int DATA_W = 8;

   typedef enum logic [OP_W-1:0] {
      no_op  = 3'b000,
      add_op = 3'b001,
      and_op = 3'b010,
      xor_op = 3'b011,
      mul_op = 3'b100
   } op_e;

   // op is kept raw so illegal codes can be
   // queued and dropped at issue time.
   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } cmd_t;

   function automatic logic op_legal(
      input logic [OP_W-1:0] op
   );
      return op <= OP_W'(mul_op);
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO of element type T.
// Ports: clk, reset (sync, high), push/wdata,
// pop/rdata (show-ahead), full, empty, count.
module cmd_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic [7:0]
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  T                       wdata,
   input  logic                   pop,
   output T                       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   T              mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; pointers define
   // which entries are live.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/alu_cmd_issuer.sv
// TinyALU command front-end: queues ops, drives
// start/op/a/b one op at a time, with a watchdog.
// Ports: clk, reset, cmd_valid/ready/op/a/b,
// alu_start/op/a/b, alu_done, busy,
// timeout_err (sticky), issued_cnt.
module alu_cmd_issuer
   import tinyalu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [OP_W-1:0]   cmd_op,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   output logic              alu_start,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic              alu_done,
   output logic              busy,
   output logic              timeout_err,
   output logic [15:0]       issued_cnt
);

   localparam int WW = $clog2(TIMEOUT);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      NOP,
      GAP
   } state_e;

   state_e            state;
   state_e            state_n;
   logic [WW-1:0]     wdog;
   logic [WW-1:0]     wdog_n;
   logic              start_n;
   logic [OP_W-1:0]   op_n;
   logic [DATA_W-1:0] a_n;
   logic [DATA_W-1:0] b_n;
   logic              terr_n;
   logic [15:0]       cnt_n;

   cmd_t              wr_cmd;
   cmd_t              head;
   logic              pop;
   logic              full;
   logic              empty;
   logic [CW-1:0]     fifo_cnt;
   logic              is_nop;
   logic              is_exec;

   assign wr_cmd = '{op: cmd_op,
                     a:  cmd_a,
                     b:  cmd_b};

   cmd_fifo #(
      .DEPTH (DEPTH),
      .T     (cmd_t)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (cmd_valid),
      .wdata (wr_cmd),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_cnt)
   );

   assign cmd_ready = !full;
   assign busy      = (state != IDLE) ||
                      (fifo_cnt != '0);

   assign is_nop  = head.op == OP_W'(no_op);
   assign is_exec = op_legal(head.op) && !is_nop;

   always_comb begin
      state_n = state;
      wdog_n  = wdog;
      start_n = alu_start;
      op_n    = alu_op;
      a_n     = alu_a;
      b_n     = alu_b;
      terr_n  = timeout_err;
      cnt_n   = issued_cnt;
      pop     = 1'b0;

      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop = 1'b1;
               // Illegal codes fall to default:
               // popped and dropped silently.
               unique case (1'b1)
                  is_nop: begin
                     start_n = 1'b1;
                     op_n    = head.op;
                     a_n     = head.a;
                     b_n     = head.b;
                     cnt_n   = issued_cnt + 16'd1;
                     state_n = NOP;
                  end
                  is_exec: begin
                     start_n = 1'b1;
                     op_n    = head.op;
                     a_n     = head.a;
                     b_n     = head.b;
                     wdog_n  = '0;
                     cnt_n   = issued_cnt + 16'd1;
                     state_n = RUN;
                  end
                  default: ;
               endcase
            end
         end
         RUN: begin
            // done has priority over timeout
            if (alu_done) begin
               start_n = 1'b0;
               state_n = GAP;
            end else if (wdog == WW'(TIMEOUT - 1)) begin
               start_n = 1'b0;
               terr_n  = 1'b1;
               state_n = GAP;
            end else begin
               wdog_n = wdog + 1'b1;
            end
         end
         NOP: begin
            start_n = 1'b0;
            state_n = GAP;
         end
         GAP: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         wdog        <= '0;
         alu_start   <= 1'b0;
         alu_op      <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         timeout_err <= 1'b0;
         issued_cnt  <= '0;
      end else begin
         state       <= state_n;
         wdog        <= wdog_n;
         alu_start   <= start_n;
         alu_op      <= op_n;
         alu_a       <= a_n;
         alu_b       <= b_n;
         timeout_err <= terr_n;
         issued_cnt  <= cnt_n;
      end
   end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer:
// queue-level reference model plus directed cases.
module tb_alu_cmd_issuer;
   import tinyalu_pkg::*;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 15;

   logic        clk       = 1'b0;
   logic        reset     = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op    = '0;
   logic [7:0]  cmd_a     = '0;
   logic [7:0]  cmd_b     = '0;
   logic        alu_start;
   logic [2:0]  alu_op;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic        alu_done  = 1'b0;
   logic        busy;
   logic        timeout_err;
   logic [15:0] issued_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_cmd_issuer #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .alu_start   (alu_start),
      .alu_op      (alu_op),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_done    (alu_done),
      .busy        (busy),
      .timeout_err (timeout_err),
      .issued_cnt  (issued_cnt)
   );

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   cmd_t        q[$];
   logic        m_start = 1'b0;
   logic [2:0]  m_op    = '0;
   logic [7:0]  m_a     = '0;
   logic [7:0]  m_b     = '0;
   logic [15:0] m_cnt   = '0;
   logic        m_terr  = 1'b0;
   logic        m_nop   = 1'b0;
   int          m_gap   = 0;
   int          m_held  = 0;
   bit          chk_en  = 1'b0;

   task automatic model_step();
      int   sz0;
      cmd_t c;
      sz0 = q.size();
      if (reset) begin
         q.delete();
         m_start = 1'b0;
         m_op    = '0;
         m_a     = '0;
         m_b     = '0;
         m_cnt   = '0;
         m_terr  = 1'b0;
         m_nop   = 1'b0;
         m_gap   = 0;
         m_held  = 0;
         return;
      end
      if (m_start) begin
         m_held++;
         if (m_nop || alu_done) begin
            m_start = 1'b0;
            m_gap   = 1;
         end else if (m_held == TIMEOUT) begin
            m_start = 1'b0;
            m_gap   = 1;
            m_terr  = 1'b1;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else if (sz0 > 0) begin
         c = q.pop_front();
         if (c.op <= 3'd4) begin
            m_start = 1'b1;
            m_held  = 0;
            m_nop   = (c.op == 3'd0);
            m_op    = c.op;
            m_a     = c.a;
            m_b     = c.b;
            m_cnt   = m_cnt + 16'd1;
         end
      end
      if (cmd_valid && sz0 < DEPTH) begin
         c.op = cmd_op;
         c.a  = cmd_a;
         c.b  = cmd_b;
         q.push_back(c);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         chk_en = 1'b1;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("m_start", 32'(alu_start), 32'(m_start));
            chk("m_op", 32'(alu_op), 32'(m_op));
            chk("m_a", 32'(alu_a), 32'(m_a));
            chk("m_b", 32'(alu_b), 32'(m_b));
            chk("m_cnt", 32'(issued_cnt), 32'(m_cnt));
            chk("m_terr", 32'(timeout_err), 32'(m_terr));
            chk("m_ready", 32'(cmd_ready),
                32'(q.size() < DEPTH));
            chk("m_busy", 32'(busy),
                32'(m_start || m_gap > 0 || q.size() > 0));
         end
      end
   end

   // ---------------- ALU / responder stand-in ---------
   logic        done_en     = 1'b0;
   logic [15:0] last_result = '0;

   function automatic logic [15:0] alu_fn(
      input logic [2:0] op,
      input logic [7:0] a,
      input logic [7:0] b);
      case (op)
         3'd1:    return 16'(a) + 16'(b);
         3'd2:    return {8'h00, a & b};
         3'd3:    return {8'h00, a ^ b};
         3'd4:    return 16'(a) * 16'(b);
         default: return 16'h0000;
      endcase
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         alu_done = alu_start && done_en;
         if (alu_done)
            last_result = alu_fn(alu_op, alu_a, alu_b);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push(input logic [2:0] op,
                       input logic [7:0] a,
                       input logic [7:0] b);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50)
         chk("push_stall", 32'(cmd_ready), 1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_start(input int lim);
      int n = 0;
      while (!alu_start && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("wait_start", 32'(alu_start), 1);
   endtask

   task automatic wait_idle(input int lim);
      int n = 0;
      while (busy && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("wait_idle", 32'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "simulation time limit");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_start", 32'(alu_start), 0);
      chk("rst_op", 32'(alu_op), 0);
      chk("rst_a", 32'(alu_a), 0);
      chk("rst_b", 32'(alu_b), 0);
      chk("rst_ready", 32'(cmd_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_terr", 32'(timeout_err), 0);
      chk("rst_cnt", 32'(issued_cnt), 0);

      // add 5+3, done one cycle after start
      done_en = 1'b1;
      push(3'd1, 8'h05, 8'h03);
      chk("add_pre", 32'(alu_start), 0);
      @(negedge clk);
      chk("add_start", 32'(alu_start), 1);
      chk("add_op", 32'(alu_op), 1);
      @(negedge clk);
      chk("add_fall", 32'(alu_start), 0);
      chk("add_cnt", 32'(issued_cnt), 1);
      chk("add_result", 32'(last_result), 32'h0008);
      repeat (3) @(negedge clk);

      // mul in flight with done held, fill FIFO
      done_en = 1'b0;
      push(3'd4, 8'd2, 8'd3);
      wait_start(10);
      push(3'd4, 8'd3, 8'd4);
      push(3'd4, 8'd5, 8'd6);
      push(3'd4, 8'd7, 8'd8);
      push(3'd4, 8'd9, 8'd10);
      chk("full_ready", 32'(cmd_ready), 0);
      chk("full_busy", 32'(busy), 1);
      cmd_valid = 1'b1;
      cmd_op    = 3'd4;
      cmd_a     = 8'd11;
      cmd_b     = 8'd12;
      repeat (3) begin
         @(negedge clk);
         chk("stall_ready", 32'(cmd_ready), 0);
      end
      done_en = 1'b1;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("stall_release", 32'(cmd_ready), 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_idle(200);
      chk("mul_cnt", 32'(issued_cnt), 7);
      chk("mul_result", 32'(last_result), 32'h0084);

      // no_op then xor
      push(3'd0, 8'h00, 8'h00);
      push(3'd3, 8'hFF, 8'h0F);
      chk("nop_start", 32'(alu_start), 1);
      chk("nop_op", 32'(alu_op), 0);
      @(negedge clk);
      chk("nop_fall", 32'(alu_start), 0);
      @(negedge clk);
      chk("nop_gap", 32'(alu_start), 0);
      @(negedge clk);
      chk("xor_start", 32'(alu_start), 1);
      chk("xor_op", 32'(alu_op), 3);
      chk("xor_a", 32'(alu_a), 32'hFF);
      chk("xor_b", 32'(alu_b), 32'h0F);
      wait_idle(50);
      chk("xor_cnt", 32'(issued_cnt), 9);
      chk("xor_result", 32'(last_result), 32'h00F0);

      // illegal op then add
      push(3'd6, 8'h01, 8'h01);
      push(3'd1, 8'h10, 8'h20);
      chk("ill_quiet", 32'(alu_start), 0);
      @(negedge clk);
      chk("ill_add_start", 32'(alu_start), 1);
      chk("ill_add_a", 32'(alu_a), 32'h10);
      wait_idle(50);
      chk("ill_cnt", 32'(issued_cnt), 10);
      chk("ill_result", 32'(last_result), 32'h0030);

      // watchdog: and never answered
      done_en = 1'b0;
      push(3'd2, 8'hAA, 8'h55);
      push(3'd1, 8'h01, 8'h02);
      wait_start(10);
      n = 0;
      while (alu_start && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("to_width", 32'(n), TIMEOUT);
      chk("to_err", 32'(timeout_err), 1);
      done_en = 1'b1;
      wait_start(10);
      chk("to_next_op", 32'(alu_op), 1);
      wait_idle(50);
      chk("to_sticky", 32'(timeout_err), 1);
      chk("to_cnt", 32'(issued_cnt), 12);

      // reset in the middle of RUN
      done_en = 1'b0;
      push(3'd4, 8'h11, 8'h22);
      push(3'd3, 8'h33, 8'h44);
      push(3'd1, 8'h55, 8'h66);
      wait_start(10);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mrst_start", 32'(alu_start), 0);
      chk("mrst_op", 32'(alu_op), 0);
      chk("mrst_a", 32'(alu_a), 0);
      chk("mrst_cnt", 32'(issued_cnt), 0);
      chk("mrst_terr", 32'(timeout_err), 0);
      chk("mrst_ready", 32'(cmd_ready), 1);
      chk("mrst_busy", 32'(busy), 0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("mrst_flushed", 32'(alu_start), 0);
      chk("mrst_idle", 32'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Synthesizable command front-end for the TinyALU. It accepts operations on a valid/ready interface and buffers them in a small FIFO. It drives the ALU start/op/A/B pins with the TinyALU start-until-done protocol, one operation at a time. It sits directly upstream of the ALU, whose done/result outputs are consumed by alu_responder; a stuck ALU is detected by a watchdog.

## Interface
- DEPTH, 4: command FIFO entries; power of two, at least 2.
- TIMEOUT, 15: maximum cycles start is held waiting for done before abort; at least 4.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  FIFO can accept; equals not-full.
- cmd_op  input  3  000 no_op, 001 add, 010 and, 011 xor, 100 mul; 101–111 illegal.
- cmd_a, cmd_b  input  8 each  operands.
- alu_start  output  1  TinyALU start.
- alu_op  output  3  TinyALU op.
- alu_a, alu_b  output  8 each  TinyALU operands.
- alu_done  input  1  TinyALU done pulse.
- busy  output  1  FSM not IDLE, or FIFO non-empty.
- timeout_err  output  1  sticky; cleared only by reset.
- issued_cnt  output  16  operations driven to the ALU; wraps 0xFFFF→0.

## Operation
- Push: a command is accepted on a clk edge where cmd_valid && cmd_ready. Push and pop in the same cycle are allowed; occupancy is unchanged.
- Full: cmd_ready = 0, and no write occurs. Empty: no pop.
- FSM states are IDLE, RUN, NOP, GAP.
- IDLE, FIFO non-empty, legal op other than no_op:
  - pop the entry;
  - register alu_op/alu_a/alu_b and set alu_start = 1;
  - clear the watchdog counter, increment issued_cnt, go to RUN.
- IDLE, FIFO non-empty, op 000: pop, alu_op = 000, alu_start = 1, increment issued_cnt, go to NOP.
- IDLE, FIFO non-empty, illegal op: pop and discard. ALU pins and issued_cnt are unchanged; stay in IDLE.
- RUN: alu_start and the operands are held stable.
  - alu_done = 1 sampled: alu_start = 0, go to GAP.
  - Else watchdog counter == TIMEOUT−1: alu_start = 0, timeout_err = 1, go to GAP.
  - Else increment the watchdog counter.
  - If done and timeout coincide on the same edge, done wins; timeout_err is not set.
- NOP: alu_start = 0, go to GAP. No done is expected for no_op.
- GAP: one cycle with start low, so the ALU sees a deasserted start; then go to IDLE.
- alu_done seen outside RUN is ignored.
- Reset mid-operation: the FIFO is flushed and the FSM returns to IDLE. All outputs return to reset values on the next edge, with no wait for done.

## Timing
- Reset values:
  - alu_start 0, alu_op 000, alu_a 0, alu_b 0;
  - cmd_ready 1 (derived from the empty FIFO), busy 0, timeout_err 0, issued_cnt 0.
- Accept at edge N with the FIFO empty and the FSM in IDLE: alu_start is high after edge N+1.
- Done sampled at edge D: alu_start is low after D; GAP occupies D+1; the next start is high after D+2.
- Minimum start-to-start period for single-cycle ops is 3 cycles (RUN, GAP, IDLE pop).
- A no_op holds alu_start high for exactly 1 cycle.
- Timeout: start is high for exactly TIMEOUT cycles.
- All outputs are registered; there is no combinational path from cmd_* to alu_*.
- cmd_ready is combinational from FIFO occupancy only.

## Structure
- Shared package (tinyalu_pkg) holds:
  - the op enum: no_op, add_op, and_op, xor_op, mul_op;
  - the packed command struct {op, A, B};
  - a constant for op width.
- Sub-module: cmd_fifo, a synchronous FIFO parameterized by DEPTH and element type, with full/empty/count.
- The FSM and watchdog live in the top module.

## Test plan
- Reset, then an idle bench: all outputs at reset values; cmd_ready = 1; busy = 0.
- Push add A=8'h05 B=8'h03; ALU model returns done 1 cycle after start:
  - start high 1 cycle after accept, alu_op = 001;
  - start low after done;
  - issued_cnt = 1; responder receives 16'h0008.
- Push 4 mul ops back-to-back while holding done low for the first:
  - cmd_ready drops after the 4th accept with DEPTH=4;
  - a 5th push is stalled;
  - after done, exactly one slot frees per pop.
- Push no_op, then xor A=8'hFF B=8'h0F: start pulses 1 cycle for no_op; xor start follows 2 cycles after its fall; issued_cnt = 2.
- Push op 3'b110, then add: the illegal op causes no pin activity; add issues normally; issued_cnt = 1.
- Push and with done never asserted: start high exactly 15 cycles; timeout_err = 1 and sticky; the next queued command still issues. Assert reset mid-RUN: outputs clear on the next edge and the FIFO is empty.
